filtro_medida: RTL and testbench
================================

# filtro_medida

Post-processing stage between `interface_hcsr04` and the 7-segment decoders. It consumes each 3-digit BCD distance (`medida`, cm) qualified by the one-cycle `pronto` pulse and rejects malformed BCD. Accepted samples are converted to binary and kept in an N-deep moving-average window. Once the window is full, the block publishes the averaged distance back in BCD together with a proximity alarm.

## Interface
- `N_AMOSTRAS`, default 4: window depth; power of two, 2..16.
- `LIMIAR_CM`, default 20: alarm threshold in cm, binary, 0..999.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `limpa`  in  1  synchronous window clear; has priority over `pronto`.
- `medida`  in  12  BCD distance, digits [11:8]/[7:4]/[3:0].
- `pronto`  in  1  one-cycle strobe; `medida` is valid in the same cycle.
- `media_bcd`  out  12  averaged distance, BCD.
- `pronto_media`  out  1  one-cycle strobe; `media_bcd` has been updated.
- `media_valida`  out  1  window full; `media_bcd` is meaningful.
- `alarme`  out  1  1 when the last published average is < `LIMIAR_CM`.
- `erro`  out  1  last offered sample had an invalid BCD digit.
- `db_estado`  out  4  FSM state code.

## Operation
- FSM states and codes: ESPERA 0, VALIDA 1, ACUMULA 2, BCD 3, FIM 4.
- ESPERA: if `pronto` is 1, register `medida` and go to VALIDA. Otherwise stay.
- VALIDA: if any digit is > 9, set `erro`, leave window/sum/outputs untouched, go to ESPERA. Otherwise clear `erro`, compute bin = d2·100 + d1·10 + d0 (10 bits), go to ACUMULA.
- ACUMULA: window buffer is circular, N × 10 bits.
  - sum ← sum − buf[ptr] + bin; buf[ptr] ← bin; ptr ← ptr+1 mod N.
  - Fill counter saturates at N.
  - If the counter is now N, go to BCD. Otherwise go to ESPERA.
- Average: avg = sum >> log2(N), floor.
  - sum width is 10+log2(N) bits; it never overflows.
  - Unwritten buffer entries are 0.
- BCD: sequential double-dabble of avg, one bit per cycle, exactly 10 cycles, then go to FIM.
- FIM: `media_bcd` ← result, `media_valida` ← 1, `alarme` ← (avg < `LIMIAR_CM`), `pronto_media` = 1; go to ESPERA.
- `pronto` seen in any state other than ESPERA is ignored. The sample is lost; no flag is raised.
- `limpa` = 1 in any state: go to ESPERA next cycle and clear sum, ptr, fill counter, buffer, `media_valida`, `alarme`, `erro`. `media_bcd` is cleared to 0.
- No `pronto_media` is issued before the window first fills. After that, every valid sample produces one.

## Timing
- Reset values: all outputs 0, `db_estado` = 0, buffer/sum/ptr/counter = 0.
- Reset asserted mid-operation (including during BCD) aborts immediately. The FSM restarts in ESPERA with the window empty.
- Cycle numbering: cycle 0 is the clock edge that samples `pronto` = 1 in ESPERA.
  - Cycle 1: VALIDA.
  - Cycle 2: ACUMULA.
  - Cycles 3–12: BCD.
  - Cycle 13: FIM.
- In cycle 13, `pronto_media` = 1 and `media_bcd`, `alarme`, `media_valida` already hold their new values. All outputs are registered.
- Busy window: a new sample is accepted no earlier than cycle 14. For a non-final fill sample, it is accepted from cycle 3.
- `erro` updates at the end of VALIDA (visible in cycle 2) and holds until the next VALIDA or `limpa`.
- `limpa` and `pronto` in the same ESPERA cycle: `limpa` wins and the sample is discarded.

## Structure
- Shared package holds:
  - state codes (ESPERA..FIM, 4 bits);
  - the 12-bit BCD width constant;
  - the 10-bit binary distance width;
  - a BCD-digit-valid helper function.
- Sub-module `bin2bcd_seq`:
  - interface: start/busy/done handshake, 10-bit in, 12-bit BCD out;
  - 10-cycle shift-add-3 converter.
  - The FSM holds in BCD until `done`, which by construction is exactly 10 cycles.
- The binary conversion, window buffer, sum and FSM live in `filtro_medida`.

## Test plan
- Reset: drive `reset` = 0 while toggling `pronto` -> all outputs 0, `db_estado` = 0. Release -> FSM stays in ESPERA.
- Fill: `pronto` with 0x010, 0x020, 0x030, 0x040 -> first `pronto_media` comes only after the 4th sample, exactly 13 cycles after its sampling edge, with `media_bcd` = 0x025, `alarme` = 0, `media_valida` = 1.
- Slide, then further samples 0x008, 0x005, 0x005 -> `media_bcd` = 0x024, 0x020, 0x014 in turn; `alarme` = 0, 0, 1.
- Invalid BCD: 0x0A3 -> `erro` = 1 in cycle 2, no `pronto_media`, next average unaffected. A following valid 0x030 -> `erro` = 0.
- Limits: four × 0x999 -> `media_bcd` = 0x999, no overflow. `pronto` during BCD -> ignored, exactly one `pronto_media`.
- Abort: `reset` = 0 during the 5th BCD cycle, or `limpa` = 1 -> ESPERA. The next three samples produce no `pronto_media` and `media_valida` stays 0.

Source files
------------

// File: rtl/filtro_medida_pkg.sv
// Shared definitions for the distance post-processing filter: FSM codes,
// data widths and the BCD digit check used on incoming samples.
package filtro_medida_pkg;

    localparam int BCD_W = 12;
    localparam int BIN_W = 10;

    typedef enum logic [3:0] {
        ESPERA  = 4'd0,
        VALIDA  = 4'd1,
        ACUMULA = 4'd2,
        BCD     = 4'd3,
        FIM     = 4'd4
    } estado_t;

    function automatic logic digito_bcd_valido(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/filtro_medida_bin2bcd_seq.sv
// Sequential double-dabble: converts a 10-bit binary value to 3 BCD digits,
// one shift per clock, with the first shift folded into the start cycle.
module bin2bcd_seq
    import filtro_medida_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    // Handshake: a one-cycle start loads bin and raises busy; done is high for
    // exactly one cycle, 10 cycles later, when bcd holds the result. bcd stays
    // stable after busy drops until the next start; start while busy restarts.
    logic [BIN_W-1:0] sr;
    logic [3:0]       passos;

    function automatic logic [BCD_W+BIN_W-1:0] passo(input logic [BCD_W-1:0] b,
                                                     input logic [BIN_W-1:0] s);
        logic [BCD_W-1:0] a;
        a = b;
        for (int i = 0; i < 3; i++) begin
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return {a, s} << 1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr     <= '0;
            bcd    <= '0;
            passos <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            {bcd, sr} <= passo('0, bin);
            passos    <= 4'd1;
            busy      <= 1'b1;
        end else if (busy) begin
            if (passos == 4'd10) begin
                busy <= 1'b0;
            end else begin
                {bcd, sr} <= passo(bcd, sr);
                passos    <= passos + 4'd1;
            end
        end
    end

    assign done = busy && (passos == 4'd10);

endmodule

// File: rtl/filtro_medida.sv
// Moving-average filter for HC-SR04 distances: validates BCD samples, keeps an
// N-deep window, and publishes the floored average in BCD with a proximity alarm.
module filtro_medida
    import filtro_medida_pkg::*;
#(
    parameter int N_AMOSTRAS = 4,
    parameter int LIMIAR_CM  = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        limpa,
    input  logic [11:0] medida,
    input  logic        pronto,
    output logic [11:0] media_bcd,
    output logic        pronto_media,
    output logic        media_valida,
    output logic        alarme,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int LOG2N = $clog2(N_AMOSTRAS);
    localparam int SUM_W = BIN_W + LOG2N;
    localparam int CNT_W = $clog2(N_AMOSTRAS + 1);

    estado_t          estado;
    logic [11:0]      amostra;
    logic [BIN_W-1:0] bin_reg;
    logic [BIN_W-1:0] janela [N_AMOSTRAS];
    logic [SUM_W-1:0] soma;
    logic [LOG2N-1:0] ptr;
    logic [CNT_W-1:0] cheio;
    logic [BIN_W-1:0] media;

    logic [SUM_W-1:0] soma_nova;
    logic [BIN_W-1:0] media_nova;
    logic [CNT_W-1:0] cheio_novo;
    logic             amostra_ok;
    logic             conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0] conv_bcd;

    // The evicted entry is subtracted before adding, so the sum never exceeds N*999.
    always_comb begin
        soma_nova  = soma - SUM_W'(janela[ptr]) + SUM_W'(bin_reg);
        media_nova = BIN_W'(soma_nova >> LOG2N);
        cheio_novo = (cheio == CNT_W'(N_AMOSTRAS)) ? cheio : cheio + 1'b1;
        amostra_ok = digito_bcd_valido(amostra[11:8]) && digito_bcd_valido(amostra[7:4])
                     && digito_bcd_valido(amostra[3:0]);
        conv_start = (estado == ACUMULA) && !limpa && (cheio_novo == CNT_W'(N_AMOSTRAS));
    end

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .bin   (media_nova),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= ESPERA;
            amostra      <= '0;
            bin_reg      <= '0;
            soma         <= '0;
            ptr          <= '0;
            cheio        <= '0;
            media        <= '0;
            media_bcd    <= '0;
            pronto_media <= 1'b0;
            media_valida <= 1'b0;
            alarme       <= 1'b0;
            erro         <= 1'b0;
            for (int i = 0; i < N_AMOSTRAS; i++) janela[i] <= '0;
        end else if (limpa) begin
            estado       <= ESPERA;
            soma         <= '0;
            ptr          <= '0;
            cheio        <= '0;
            media_bcd    <= '0;
            pronto_media <= 1'b0;
            media_valida <= 1'b0;
            alarme       <= 1'b0;
            erro         <= 1'b0;
            for (int i = 0; i < N_AMOSTRAS; i++) janela[i] <= '0;
        end else begin
            pronto_media <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (pronto) begin
                        amostra <= medida;
                        estado  <= VALIDA;
                    end
                end
                VALIDA: begin
                    if (!amostra_ok) begin
                        erro   <= 1'b1;
                        estado <= ESPERA;
                    end else begin
                        erro    <= 1'b0;
                        bin_reg <= BIN_W'(amostra[11:8]) * 10'd100
                                 + BIN_W'(amostra[7:4]) * 10'd10
                                 + BIN_W'(amostra[3:0]);
                        estado  <= ACUMULA;
                    end
                end
                ACUMULA: begin
                    soma        <= soma_nova;
                    janela[ptr] <= bin_reg;
                    ptr         <= ptr + 1'b1;
                    cheio       <= cheio_novo;
                    media       <= media_nova;
                    estado      <= (cheio_novo == CNT_W'(N_AMOSTRAS)) ? BCD : ESPERA;
                end
                BCD: begin
                    // Outputs are loaded on the way into FIM so they are valid with the strobe.
                    if (conv_done) begin
                        media_bcd    <= conv_bcd;
                        media_valida <= 1'b1;
                        alarme       <= (media < BIN_W'(LIMIAR_CM));
                        pronto_media <= 1'b1;
                        estado       <= FIM;
                    end else if (!conv_busy) begin
                        estado <= ESPERA;
                    end
                end
                FIM:     estado <= ESPERA;
                default: estado <= ESPERA;
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_filtro_medida.sv
// Directed bench for filtro_medida: a table of samples with hand-computed
// averages, plus sequences for clear, limits, ignored strobes and aborts.
module tb_filtro_medida;

    logic        clock = 1'b0;
    logic        reset;
    logic        limpa;
    logic [11:0] medida;
    logic        pronto;
    logic [11:0] media_bcd;
    logic        pronto_media;
    logic        media_valida;
    logic        alarme;
    logic        erro;
    logic [3:0]  db_estado;

    int n_aval  = 0;
    int n_falha = 0;

    filtro_medida #(.N_AMOSTRAS(4), .LIMIAR_CM(20)) dut (
        .clock        (clock),
        .reset        (reset),
        .limpa        (limpa),
        .medida       (medida),
        .pronto       (pronto),
        .media_bcd    (media_bcd),
        .pronto_media (pronto_media),
        .media_valida (media_valida),
        .alarme       (alarme),
        .erro         (erro),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [11:0] medida;
        logic        erro;
        int          n_pm;
        logic [11:0] bcd;
        logic        alarme;
        logic        valida;
    } vetor_t;

    vetor_t tab [9];

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_aval++;
        if (atual !== esperado) begin
            n_falha++;
            $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
        end
    endtask

    // Called at a negedge; offers one sample and watches the next 15 cycles.
    task automatic envia(input logic [11:0] m, input int inj_c, output int pm_n, output int pm_c,
                         output logic erro_c2, output logic [3:0] est_c1, output logic [3:0] est_fim);
        pm_n    = 0;
        pm_c    = 0;
        erro_c2 = 1'b0;
        est_c1  = 4'd0;
        medida  = m;
        pronto  = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            pronto = (c == inj_c);
            if (c == inj_c) medida = 12'h000;
            if (c == 1) est_c1 = db_estado;
            if (c == 2) erro_c2 = erro;
            if (pronto_media) begin
                pm_n++;
                pm_c = c;
            end
        end
        est_fim = db_estado;
        pronto  = 1'b0;
    endtask

    int         pm_n, pm_c;
    logic       e2;
    logic [3:0] s1, sf;

    initial begin
        tab[0] = '{12'h010, 1'b0, 0, 12'h000, 1'b0, 1'b0};
        tab[1] = '{12'h020, 1'b0, 0, 12'h000, 1'b0, 1'b0};
        tab[2] = '{12'h030, 1'b0, 0, 12'h000, 1'b0, 1'b0};
        tab[3] = '{12'h040, 1'b0, 1, 12'h025, 1'b0, 1'b1};
        tab[4] = '{12'h008, 1'b0, 1, 12'h024, 1'b0, 1'b1};
        tab[5] = '{12'h005, 1'b0, 1, 12'h020, 1'b0, 1'b1};
        tab[6] = '{12'h005, 1'b0, 1, 12'h014, 1'b1, 1'b1};
        tab[7] = '{12'h0A3, 1'b1, 0, 12'h014, 1'b1, 1'b1};
        tab[8] = '{12'h030, 1'b0, 1, 12'h012, 1'b1, 1'b1};

        reset  = 1'b0;
        limpa  = 1'b0;
        pronto = 1'b0;
        medida = 12'h123;

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            pronto = ~pronto;
            verifica("reset_outputs", {16'h0, media_bcd, pronto_media, media_valida, alarme, erro},
                     32'h0);
            verifica("reset_estado", {28'h0, db_estado}, 32'h0);
        end
        @(negedge clock);
        reset  = 1'b1;
        pronto = 1'b0;
        repeat (3) @(negedge clock);
        verifica("post_reset_estado", {28'h0, db_estado}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            envia(tab[i].medida, 0, pm_n, pm_c, e2, s1, sf);
            verifica($sformatf("vec%0d_estado_c1", i), {28'h0, s1}, 32'd1);
            verifica($sformatf("vec%0d_erro_c2", i), {31'h0, e2}, {31'h0, tab[i].erro});
            verifica($sformatf("vec%0d_n_pronto_media", i), pm_n, tab[i].n_pm);
            if (tab[i].n_pm == 1) verifica($sformatf("vec%0d_latencia", i), pm_c, 32'd13);
            verifica($sformatf("vec%0d_media_bcd", i), {20'h0, media_bcd}, {20'h0, tab[i].bcd});
            verifica($sformatf("vec%0d_alarme", i), {31'h0, alarme}, {31'h0, tab[i].alarme});
            verifica($sformatf("vec%0d_valida", i), {31'h0, media_valida}, {31'h0, tab[i].valida});
        end

        // Invalid sample sets erro, then limpa together with pronto clears and discards it.
        envia(12'h0F0, 0, pm_n, pm_c, e2, s1, sf);
        verifica("inval_erro", {31'h0, e2}, 32'd1);
        limpa  = 1'b1;
        pronto = 1'b1;
        medida = 12'h050;
        @(negedge clock);
        limpa  = 1'b0;
        pronto = 1'b0;
        verifica("limpa_estado", {28'h0, db_estado}, 32'h0);
        verifica("limpa_saidas", {16'h0, media_bcd, pronto_media, media_valida, alarme, erro}, 32'h0);
        repeat (3) @(negedge clock);
        verifica("limpa_descarta", {28'h0, db_estado}, 32'h0);

        // Full-scale window, with a stray strobe during conversion.
        for (int i = 0; i < 3; i++) begin
            envia(12'h999, 0, pm_n, pm_c, e2, s1, sf);
            verifica("lim_sem_pm", pm_n, 32'd0);
        end
        envia(12'h999, 6, pm_n, pm_c, e2, s1, sf);
        verifica("lim_n_pm", pm_n, 32'd1);
        verifica("lim_latencia", pm_c, 32'd13);
        verifica("lim_media_bcd", {20'h0, media_bcd}, 32'h999);
        verifica("lim_alarme", {31'h0, alarme}, 32'd0);
        verifica("lim_ignora_pronto", {28'h0, sf}, 32'd0);

        // Reset in the 5th conversion cycle.
        medida = 12'h100;
        pronto = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            pronto = 1'b0;
        end
        verifica("abort_em_bcd", {28'h0, db_estado}, 32'd3);
        reset = 1'b0;
        #1;
        verifica("abort_reset_saidas", {16'h0, media_bcd, pronto_media, media_valida, alarme, erro},
                 32'h0);
        verifica("abort_reset_estado", {28'h0, db_estado}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            envia(12'(i * 256), 0, pm_n, pm_c, e2, s1, sf);
            verifica("abort_reset_sem_pm", pm_n, 32'd0);
            verifica("abort_reset_valida", {31'h0, media_valida}, 32'd0);
        end
        envia(12'h400, 0, pm_n, pm_c, e2, s1, sf);
        verifica("refill_n_pm", pm_n, 32'd1);
        verifica("refill_media_bcd", {20'h0, media_bcd}, 32'h250);
        verifica("refill_alarme", {31'h0, alarme}, 32'd0);

        // limpa during conversion.
        medida = 12'h100;
        pronto = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            pronto = 1'b0;
        end
        limpa = 1'b1;
        @(negedge clock);
        limpa = 1'b0;
        verifica("abort_limpa_estado", {28'h0, db_estado}, 32'h0);
        verifica("abort_limpa_saidas", {16'h0, media_bcd, pronto_media, media_valida, alarme, erro},
                 32'h0);
        for (int i = 0; i < 3; i++) begin
            envia(12'h012, 0, pm_n, pm_c, e2, s1, sf);
            verifica("abort_limpa_sem_pm", pm_n, 32'd0);
            verifica("abort_limpa_valida", {31'h0, media_valida}, 32'd0);
        end
        envia(12'h012, 0, pm_n, pm_c, e2, s1, sf);
        verifica("limpa_refill_n_pm", pm_n, 32'd1);
        verifica("limpa_refill_media_bcd", {20'h0, media_bcd}, 32'h012);
        verifica("limpa_refill_alarme", {31'h0, alarme}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falha);
        $finish;
    end

endmodule
